// File: rtl/cdf_pkg.sv
// Shared constants, state encoding and sizing helpers for the CDF engine.
package cdf_pkg;

  localparam int DATA_W_DEF   = 128;
  localparam int ADDR_W_DEF   = 16;
  localparam int BIN_W_DEF    = 16;
  localparam int NUM_BINS_DEF = 256;

  localparam int LANES_DEF     = DATA_W_DEF / BIN_W_DEF;
  localparam int NUM_WORDS_DEF = NUM_BINS_DEF / LANES_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } cdf_state_e;

  // Index width that stays legal when the count collapses to one.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdf_prefix_lanes.sv
// Combinational saturating prefix sum across the bins of one word, seeded by
// the running carry; also reports the lowest lane whose CDF is non-zero.
module cdf_prefix_lanes
  import cdf_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF,
  parameter int LANES = LANES_DEF
) (
  input  logic [BIN_W-1:0]         carry_i,
  input  logic [LANES*BIN_W-1:0]   word_i,
  output logic [LANES*BIN_W-1:0]   cdf_o,
  output logic                     sat_o,
  output logic [idx_w(LANES)-1:0]  nz_idx_o,
  output logic                     nz_valid_o
);

  localparam int LIDX_W = idx_w(LANES);

  // One extra bit catches the carry out; clamping each step keeps later lanes saturated.
  logic [BIN_W:0] acc;

  always_comb begin
    acc        = {1'b0, carry_i};
    cdf_o      = '0;
    sat_o      = 1'b0;
    nz_idx_o   = '0;
    nz_valid_o = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      acc = acc + {1'b0, word_i[j*BIN_W +: BIN_W]};
      if (acc[BIN_W]) begin
        acc   = {1'b0, {BIN_W{1'b1}}};
        sat_o = 1'b1;
      end
      cdf_o[j*BIN_W +: BIN_W] = acc[BIN_W-1:0];
      if (!nz_valid_o && (acc[BIN_W-1:0] != '0)) begin
        nz_valid_o = 1'b1;
        nz_idx_o   = LIDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/cdf_engine.sv
// Streams a histogram out of scratch memory and writes back its cumulative
// distribution one word per clock, reporting min, total and overflow.
module cdf_engine
  import cdf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int BIN_W    = BIN_W_DEF,
  parameter int NUM_BINS = NUM_BINS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cdf_start_in,
  input  logic [ADDR_W-1:0] hist_base_in,
  input  logic [ADDR_W-1:0] cdf_base_in,
  output logic [ADDR_W-1:0] ReadAddress1,
  input  logic [DATA_W-1:0] ReadBus1,
  output logic              WE,
  output logic [ADDR_W-1:0] WriteAddress,
  output logic [DATA_W-1:0] WriteBus,
  output logic              cdf_busy,
  output logic              cdf_done,
  output logic [BIN_W-1:0]  cdf_min,
  output logic [BIN_W-1:0]  cdf_total,
  output logic              cdf_overflow,
  output cdf_state_e        state_o
);

  localparam int LANES     = DATA_W / BIN_W;
  localparam int NUM_WORDS = NUM_BINS / LANES;
  localparam int IDX_W     = idx_w(NUM_WORDS);
  localparam int LIDX_W    = idx_w(LANES);

  cdf_state_e        state_q, state_d;
  logic              start_prev_q;
  logic [ADDR_W-1:0] hist_base_q, hist_base_d;
  logic [ADDR_W-1:0] cdf_base_q, cdf_base_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BIN_W-1:0]  carry_q, carry_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wbus_q, wbus_d;
  logic [BIN_W-1:0]  min_q, min_d;
  logic [BIN_W-1:0]  total_q, total_d;
  logic              ovf_q, ovf_d;

  logic [DATA_W-1:0] cdf_word;
  logic              sat;
  logic [LIDX_W-1:0] nz_idx;
  logic              nz_valid;
  logic              start_rise;

  cdf_prefix_lanes #(
    .BIN_W (BIN_W),
    .LANES (LANES)
  ) u_prefix (
    .carry_i    (carry_q),
    .word_i     (ReadBus1),
    .cdf_o      (cdf_word),
    .sat_o      (sat),
    .nz_idx_o   (nz_idx),
    .nz_valid_o (nz_valid)
  );

  // The previous level is tracked in every state so a held start cannot retrigger.
  assign start_rise = cdf_start_in & ~start_prev_q;

  always_comb begin
    state_d     = state_q;
    hist_base_d = hist_base_q;
    cdf_base_d  = cdf_base_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    we_d        = we_q;
    waddr_d     = waddr_q;
    wbus_d      = wbus_q;
    min_d       = min_q;
    total_d     = total_q;
    ovf_d       = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d     = ST_RUN;
          hist_base_d = hist_base_in;
          cdf_base_d  = cdf_base_in;
          idx_d       = '0;
          carry_d     = '0;
          min_d       = '0;
          total_d     = '0;
          ovf_d       = 1'b0;
        end
      end
      ST_RUN: begin
        wbus_d  = cdf_word;
        waddr_d = cdf_base_q + ADDR_W'(idx_q);
        we_d    = 1'b1;
        carry_d = cdf_word[(LANES-1)*BIN_W +: BIN_W];
        if (sat) ovf_d = 1'b1;
        if ((min_q == '0) && nz_valid) min_d = cdf_word[nz_idx*BIN_W +: BIN_W];
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(NUM_WORDS - 1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        we_d    = 1'b0;
        total_d = carry_q;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      start_prev_q <= 1'b0;
      hist_base_q  <= '0;
      cdf_base_q   <= '0;
      idx_q        <= '0;
      carry_q      <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wbus_q       <= '0;
      min_q        <= '0;
      total_q      <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= cdf_start_in;
      hist_base_q  <= hist_base_d;
      cdf_base_q   <= cdf_base_d;
      idx_q        <= idx_d;
      carry_q      <= carry_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wbus_q       <= wbus_d;
      min_q        <= min_d;
      total_q      <= total_d;
      ovf_q        <= ovf_d;
    end
  end

  assign ReadAddress1 = (state_q == ST_RUN) ? (hist_base_q + ADDR_W'(idx_q)) : '0;
  assign WE           = we_q;
  assign WriteAddress = waddr_q;
  assign WriteBus     = wbus_q;
  assign cdf_busy     = (state_q != ST_IDLE);
  assign cdf_done     = (state_q == ST_DONE);
  assign cdf_min      = min_q;
  assign cdf_total    = total_q;
  assign cdf_overflow = ovf_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_cdf_engine.sv
// Directed bench for cdf_engine with a behavioural scratch memory.
module tb_cdf_engine;
  import cdf_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [15:0]  hist_base, cdf_base;
  logic [15:0]  raddr, waddr;
  logic [127:0] rbus, wbus;
  logic         we, busy, done, ovf;
  logic [15:0]  cmin, ctotal;
  cdf_state_e   state;

  logic [127:0] mem [65536];
  logic         pl_we, cnt_clr;
  logic [15:0]  pl_addr;
  logic [127:0] pl_data;
  int           we_cnt, done_cnt;

  logic [15:0]  hist [256];
  logic [15:0]  exp_bin [256];
  logic [127:0] exp_q [$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cdf_engine dut (
    .clk          (clk),
    .reset        (rst_n),
    .cdf_start_in (start),
    .hist_base_in (hist_base),
    .cdf_base_in  (cdf_base),
    .ReadAddress1 (raddr),
    .ReadBus1     (rbus),
    .WE           (we),
    .WriteAddress (waddr),
    .WriteBus     (wbus),
    .cdf_busy     (busy),
    .cdf_done     (done),
    .cdf_min      (cmin),
    .cdf_total    (ctotal),
    .cdf_overflow (ovf),
    .state_o      (state)
  );

  assign rbus = mem[raddr];

  always @(posedge clk) begin
    if (we) mem[waddr] <= wbus;
    if (pl_we) mem[pl_addr] <= pl_data;
    if (cnt_clr) begin
      we_cnt   <= 0;
      done_cnt <= 0;
    end else begin
      if (we) we_cnt <= we_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_word(input logic [15:0] a, input logic [127:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic load_hist(input logic [15:0] base);
    logic [127:0] w;
    for (int k = 0; k < 32; k++) begin
      for (int j = 0; j < 8; j++) w[j*16 +: 16] = hist[k*8+j];
      load_word(base + 16'(k), w);
    end
  endtask

  task automatic clear_region(input logic [15:0] base);
    for (int k = 0; k < 32; k++) load_word(base + 16'(k), '0);
  endtask

  task automatic push_exp();
    logic [127:0] w;
    for (int k = 0; k < 32; k++) begin
      for (int j = 0; j < 8; j++) w[j*16 +: 16] = exp_bin[k*8+j];
      exp_q.push_back(w);
    end
  endtask

  task automatic check_region(input logic [15:0] base, input int words, input string tag);
    logic [127:0] e;
    for (int k = 0; k < words; k++) begin
      e = exp_q.pop_front();
      check(tag, mem[base + 16'(k)], e);
    end
    exp_q.delete();
  endtask

  task automatic run_cdf(input logic [15:0] hb, input logic [15:0] cb, input string tag);
    int done_n;
    done_n = 0;
    hist_base = hb; cdf_base = cb; start = 1'b1; cnt_clr = 1'b1;
    for (int n = 1; n <= 100 && done_n == 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0; cnt_clr = 1'b0;
        check({tag, " busy"}, 128'(busy), 128'd1);
        check({tag, " raddr0"}, 128'(raddr), 128'(hb));
      end
      if (n == 2) check({tag, " raddr1"}, 128'(raddr), 128'(hb + 16'd1));
      if (done) done_n = n;
    end
    check({tag, " done_cycle"}, 128'(done_n), 128'd34);
    check({tag, " we_count"}, 128'(we_cnt), 128'd32);
    @(negedge clk);
    check({tag, " done_pulses"}, 128'(done_cnt), 128'd1);
    check({tag, " idle_busy"}, 128'(busy), 128'd0);
    check({tag, " idle_raddr"}, 128'(raddr), 128'd0);
  endtask

  task automatic model_from_hist();
    int acc;
    acc = 0;
    for (int i = 0; i < 256; i++) begin
      acc = acc + int'(hist[i]);
      if (acc > 65535) acc = 65535;
      exp_bin[i] = 16'(acc);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; hist_base = '0; cdf_base = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0; cnt_clr = 1'b1;
    repeat (3) @(negedge clk);
    check("rst WE", 128'(we), 128'd0);
    check("rst waddr", 128'(waddr), 128'd0);
    check("rst wbus", wbus, 128'd0);
    check("rst busy", 128'(busy), 128'd0);
    check("rst done", 128'(done), 128'd0);
    check("rst min", 128'(cmin), 128'd0);
    check("rst total", 128'(ctotal), 128'd0);
    check("rst ovf", 128'(ovf), 128'd0);
    check("rst raddr", 128'(raddr), 128'd0);
    check("rst state", 128'(state), 128'(ST_IDLE));
    rst_n = 1'b1; cnt_clr = 1'b0;
    @(negedge clk);

    // All ones: CDF bin i = i+1.
    for (int i = 0; i < 256; i++) hist[i] = 16'd1;
    load_hist(16'h0000);
    for (int i = 0; i < 256; i++) exp_bin[i] = 16'(i + 1);
    push_exp();
    run_cdf(16'h0000, 16'h0100, "ones");
    check("ones word0", mem[16'h0100], 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    check_region(16'h0100, 32, "ones region");
    check("ones total", 128'(ctotal), 128'd256);
    check("ones min", 128'(cmin), 128'd1);
    check("ones ovf", 128'(ovf), 128'd0);

    // Single spike at bin 100.
    for (int i = 0; i < 256; i++) hist[i] = 16'd0;
    hist[100] = 16'd4096;
    load_hist(16'h0000);
    for (int i = 0; i < 256; i++) exp_bin[i] = (i >= 100) ? 16'd4096 : 16'd0;
    push_exp();
    run_cdf(16'h0000, 16'h0200, "spike");
    check_region(16'h0200, 32, "spike region");
    check("spike min", 128'(cmin), 128'd4096);
    check("spike total", 128'(ctotal), 128'd4096);
    check("spike ovf", 128'(ovf), 128'd0);

    // Saturation in the first word.
    for (int i = 0; i < 256; i++) hist[i] = 16'd0;
    hist[0] = 16'hFFFF; hist[1] = 16'hFFFF;
    load_hist(16'h0000);
    for (int i = 0; i < 256; i++) exp_bin[i] = 16'hFFFF;
    push_exp();
    run_cdf(16'h0000, 16'h0100, "sat");
    check_region(16'h0100, 32, "sat region");
    check("sat ovf", 128'(ovf), 128'd1);
    check("sat total", 128'(ctotal), 128'hFFFF);
    check("sat min", 128'(cmin), 128'hFFFF);

    // Random bins: out-of-place golden, then in place at 0x0040.
    for (int i = 0; i < 256; i++) hist[i] = 16'($urandom_range(0, 255));
    load_hist(16'h0040);
    model_from_hist();
    push_exp();
    run_cdf(16'h0040, 16'h0300, "golden");
    check_region(16'h0300, 32, "golden region");
    check("golden total", 128'(ctotal), 128'(exp_bin[255]));
    push_exp();
    run_cdf(16'h0040, 16'h0040, "inplace");
    check_region(16'h0040, 32, "inplace model");
    for (int k = 0; k < 32; k++)
      check("inplace vs golden", mem[16'h0040 + 16'(k)], mem[16'h0300 + 16'(k)]);

    // Held start then a stray pulse mid-run: one run only.
    hist_base = 16'h0000; cdf_base = 16'h0100; start = 1'b1; cnt_clr = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) cnt_clr = 1'b0;
      if (n == 3) start = 1'b0;
      if (n == 10) start = 1'b1;
      if (n == 11) start = 1'b0;
    end
    check("held done_pulses", 128'(done_cnt), 128'd1);
    check("held we_count", 128'(we_cnt), 128'd32);

    // Reset while word 10 is on the write bus.
    for (int i = 0; i < 256; i++) hist[i] = 16'd1;
    load_hist(16'h0000);
    clear_region(16'h0100);
    hist_base = 16'h0000; cdf_base = 16'h0100; start = 1'b1; cnt_clr = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) begin start = 1'b0; cnt_clr = 1'b0; end
    end
    check("midrst pre WE", 128'(we), 128'd1);
    check("midrst pre waddr", 128'(waddr), 128'h010A);
    rst_n = 1'b0;
    #1;
    check("midrst WE", 128'(we), 128'd0);
    check("midrst busy", 128'(busy), 128'd0);
    check("midrst min", 128'(cmin), 128'd0);
    check("midrst waddr", 128'(waddr), 128'd0);
    check("midrst wbus", wbus, 128'd0);
    check("midrst raddr", 128'(raddr), 128'd0);
    check("midrst we_count", 128'(we_cnt), 128'd10);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 256; i++) exp_bin[i] = 16'(i + 1);
    push_exp();
    check_region(16'h0100, 10, "midrst written");
    check("midrst word10", mem[16'h010A], 128'd0);
    check("midrst no resume", 128'(we_cnt), 128'd10);

    // Fresh run after the aborted one.
    for (int i = 0; i < 256; i++) exp_bin[i] = 16'(i + 1);
    push_exp();
    run_cdf(16'h0000, 16'h0100, "rerun");
    check_region(16'h0100, 32, "rerun region");
    check("rerun total", 128'(ctotal), 128'd256);
    check("rerun min", 128'(cmin), 128'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdf_engine.md
# cdf_engine

Parametrised single-block successor to the split cdf_control/cdf_datapath pair. It reads a histogram from scratch memory and writes the cumulative distribution (CDF) back to a separate or identical address range. Words move through a 2-stage pipeline at 1 word/clock. It adds per-word multi-lane prefix summing, saturation with a sticky overflow flag, and cdf_min/cdf_total reporting for the equalisation stage that follows it.

## Interface
Parameters:
- DATA_W, 128, scratch-memory word width
- ADDR_W, 16, scratch-memory address width
- BIN_W, 16, width of one histogram/CDF bin; DATA_W must be a multiple of BIN_W
- NUM_BINS, 256, bin count; must be a multiple of LANES = DATA_W/BIN_W

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- cdf_start_in  in  1  start request, rising-edge detected
- hist_base_in  in  ADDR_W  first histogram word address, sampled at start
- cdf_base_in  in  ADDR_W  first CDF word address, sampled at start
- ReadAddress1  out  ADDR_W  scratch read address
- ReadBus1  in  DATA_W  scratch read data, combinational from ReadAddress1
- WE  out  1  scratch write enable
- WriteAddress  out  ADDR_W  scratch write address
- WriteBus  out  DATA_W  scratch write data
- cdf_busy  out  1  high from accepted start through DONE
- cdf_done  out  1  one-cycle completion pulse
- cdf_min  out  BIN_W  first non-zero CDF value; 0 if the histogram is all zero
- cdf_total  out  BIN_W  final CDF value, saturated
- cdf_overflow  out  1  sticky: some sum saturated during the last run

## Operation
- Lane order: lane j occupies bits [j*BIN_W +: BIN_W]. Bin index = word*LANES + j. Lane 0 is the lowest bin.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: a rising edge of cdf_start_in (low last cycle, high this cycle) does the following. It latches hist_base and cdf_base, clears idx, carry, cdf_min, cdf_total and cdf_overflow, and moves to RUN. A level held high never triggers a second run.
- RUN: ReadAddress1 = hist_base + idx. Each lane computes cdf[j] = carry + sum of hist[0..j] for that word, saturating at 2^BIN_W-1. Any saturation sets overflow.
  - On each edge: the result registers into WriteBus, WriteAddress = cdf_base + idx and WE = 1. carry takes cdf[LANES-1]. If cdf_min is 0 and a lane is non-zero, cdf_min captures the lowest such lane.
  - idx increments. After idx = NUM_WORDS-1 (NUM_WORDS = NUM_BINS/LANES), move to DRAIN.
- DRAIN: the final write is presented on the bus. WE deasserts at the next edge. Move to DONE.
- DONE: cdf_done = 1 for one cycle, cdf_total = carry. Return to IDLE.
- cdf_start_in edges seen outside IDLE are ignored.
- ReadAddress1 = 0 outside RUN.
- In-place operation (hist_base == cdf_base) is legal. Word k is written the cycle that word k+1 is read, and addresses strictly increase, so there is no hazard.
- Address arithmetic wraps modulo 2^ADDR_W.

## Timing
- Reset values: WE, WriteAddress, WriteBus, cdf_busy, cdf_done, cdf_min, cdf_total and cdf_overflow are all 0. ReadAddress1 is 0. State is IDLE.
- Cycle numbering: cycle 0 is the edge that accepts start. Reads of word k happen in cycle k+1 (k = 0..NUM_WORDS-1). WE is high in cycles 2..NUM_WORDS+1. cdf_done is high in cycle NUM_WORDS+2. With the defaults (NUM_WORDS = 32), done is at cycle 34.
- cdf_busy is high in cycles 1..NUM_WORDS+2. The next start is accepted from cycle NUM_WORDS+3.
- cdf_min, cdf_total and cdf_overflow hold their values until the next accepted start.
- Reset asserted mid-run: every output goes to 0 asynchronously and WE drops immediately. Words already written remain in memory. Writes do not resume after reset releases.

## Structure
- Package cdf_pkg holds:
  - the state encoding (IDLE/RUN/DRAIN/DONE);
  - default DATA_W/ADDR_W/BIN_W/NUM_BINS constants;
  - the LANES and NUM_WORDS derivations.
- Sub-module cdf_prefix_lanes holds the combinational LANES-wide saturating prefix adder. Inputs are carry and the word. Outputs are the CDF word, the saturation flag and the first-non-zero index/valid.

## Test plan
- All 256 bins = 1, hist_base = 0x0000, cdf_base = 0x0100 -> CDF bin i = i+1. Word 0 = {8,7,...,1}. cdf_total = 256, cdf_min = 1, cdf_overflow = 0, cdf_done in cycle 34.
- Bin 100 = 4096, all other bins 0 -> bins 0..99 = 0 and bins 100..255 = 4096. cdf_min = 4096, cdf_total = 4096.
- Bins 0 and 1 = 0xFFFF, all other bins 0 -> every CDF bin from 0 onward = 0xFFFF. cdf_overflow = 1, cdf_total = 0xFFFF.
- In-place run with both bases = 0x0040 and random bins -> memory contents are identical to an out-of-place golden run. Exactly 32 WE cycles occur.
- cdf_start_in held high for 3 cycles, then pulsed again at cycle 10 -> exactly one run and one cdf_done.
- Reset asserted while writing word 10 -> WE = 0 in the same cycle and all outputs = 0. Words 0..9 are written. A new start afterwards completes correctly in 34 cycles.
